// File: rtl/alu_control_sequencer.sv
// Instruction sequencer for a single-bus datapath: fetches one instruction per
// start request, decodes the opcode and steps the datapath through T0..T6.
//
// state | meaning
// IDLE  | waiting for start; carries the one-cycle done/illegal pulse
// T0    | PC to MAR, increment PC into Z
// T1    | Z to PC, memory read into MDR
// T2    | MDR to IR
// T3    | decode; binary ops load Rb into Y
// T4    | ALU operation into Z
// T5    | Z low to destination (Ra, or LO for MUL/DIV)
// T6    | Z high to HI (MUL/DIV only)
// HALT  | stopped until reset
module alu_control_sequencer (
    input  logic        Clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        HIin,
    output logic        LOin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  op,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    typedef struct packed {
        logic        pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
        logic        y_in, z_in, zhigh_out, zlow_out, hi_in, lo_in;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  op;
        logic        busy, done, illegal, halted;
    } ctl_t;

    state_t state;
    state_t nxt;
    ctl_t   ctl;

    // Only the opcode and register fields steer the sequencer.
    logic unused_ir;
    assign unused_ir = ^IR[14:0];

    function automatic logic is_binary(input logic [4:0] opc);
        return opc <= 5'd9;
    endfunction

    function automatic logic is_unary(input logic [4:0] opc);
        return (opc == 5'd10) || (opc == 5'd11);
    endfunction

    function automatic logic is_muldiv(input logic [4:0] opc);
        return (opc == 5'd8) || (opc == 5'd9);
    endfunction

    function automatic state_t next_state(input state_t s, input logic st, input logic [4:0] opc);
        state_t n;
        n = s;
        case (s)
            S_IDLE: n = st ? S_T0 : S_IDLE;
            S_T0:   n = S_T1;
            S_T1:   n = S_T2;
            S_T2:   n = S_T3;
            S_T3: begin
                if (is_binary(opc) || is_unary(opc)) n = S_T4;
                else if (opc == 5'd31)               n = S_HALT;
                else                                 n = S_IDLE;
            end
            S_T4:   n = S_T5;
            S_T5:   n = is_muldiv(opc) ? S_T6 : S_IDLE;
            S_T6:   n = S_IDLE;
            S_HALT: n = S_HALT;
            default: n = S_IDLE;
        endcase
        return n;
    endfunction

    // Outputs for the state about to be entered; cur tells IDLE which pulse to carry.
    function automatic ctl_t decode(input state_t cur, input state_t n, input logic [31:0] ir);
        ctl_t       c;
        logic [4:0] opc;
        opc = ir[31:27];
        c   = '0;
        case (n)
            S_IDLE: begin
                c.done    = (cur == S_T5) || (cur == S_T6);
                c.illegal = (cur == S_T3);
            end
            S_T0: begin
                c.pc_out = 1'b1;
                c.mar_in = 1'b1;
                c.inc_pc = 1'b1;
                c.z_in   = 1'b1;
            end
            S_T1: begin
                c.zlow_out = 1'b1;
                c.pc_in    = 1'b1;
                c.read     = 1'b1;
                c.mdr_in   = 1'b1;
            end
            S_T2: begin
                c.mdr_out = 1'b1;
                c.ir_in   = 1'b1;
            end
            S_T3: begin
                if (is_binary(opc)) begin
                    c.rout = 16'(1) << ir[22:19];
                    c.y_in = 1'b1;
                end
            end
            S_T4: begin
                c.z_in = 1'b1;
                c.op   = opc;
                c.rout = is_binary(opc) ? (16'(1) << ir[18:15]) : (16'(1) << ir[22:19]);
            end
            S_T5: begin
                c.zlow_out = 1'b1;
                if (is_muldiv(opc)) c.lo_in = 1'b1;
                else                c.rin   = 16'(1) << ir[26:23];
            end
            S_T6: begin
                c.zhigh_out = 1'b1;
                c.hi_in     = 1'b1;
            end
            S_HALT: c.halted = 1'b1;
            default: c = '0;
        endcase
        c.busy = (n != S_IDLE) && (n != S_HALT);
        return c;
    endfunction

    assign nxt = next_state(state, start, IR[31:27]);

    // State register with outputs registered alongside it.
    always_ff @(posedge Clock) begin
        if (!clear) begin
            state <= S_IDLE;
            ctl   <= '0;
        end else begin
            state <= nxt;
            ctl   <= decode(state, nxt, IR);
        end
    end

    assign PCout    = ctl.pc_out;
    assign PCin     = ctl.pc_in;
    assign IncPC    = ctl.inc_pc;
    assign MARin    = ctl.mar_in;
    assign Read     = ctl.read;
    assign MDRin    = ctl.mdr_in;
    assign MDRout   = ctl.mdr_out;
    assign IRin     = ctl.ir_in;
    assign Yin      = ctl.y_in;
    assign Zin      = ctl.z_in;
    assign Zhighout = ctl.zhigh_out;
    assign Zlowout  = ctl.zlow_out;
    assign HIin     = ctl.hi_in;
    assign LOin     = ctl.lo_in;
    assign Rin      = ctl.rin;
    assign Rout     = ctl.rout;
    assign op       = ctl.op;
    assign busy     = ctl.busy;
    assign done     = ctl.done;
    assign illegal  = ctl.illegal;
    assign halted   = ctl.halted;

endmodule
